// File: rtl/div_8bits.sv
// rtl/div_8bits.sv - 8-bit unsigned restoring divider built around the sub_8bits trial-subtraction stage
// One trial subtraction per cycle: s[8] is the borrow, s[7:0] the candidate partial remainder.

module sub_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] s
);
  assign s = {1'b0, a} - {1'b0, b};
endmodule

module div_8bits (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  d_q, d_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  quotient_q, quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        dbz_q, dbz_d;

  logic [7:0]  trial;
  logic        msb;
  logic [8:0]  sub_s;
  logic        take;
  logic [7:0]  r_next;
  logic [7:0]  q_next;

  assign trial = {r_q[6:0], q_q[7]};
  assign msb   = r_q[7];

  sub_8bits u_sub (
    .a (trial),
    .b (d_q),
    .s (sub_s)
  );

  // A set msb means the shifted remainder is >= 256 > D, so the wrapped difference is exact.
  assign take   = msb | ~sub_s[8];
  assign r_next = take ? sub_s[7:0] : trial;
  assign q_next = {q_q[6:0], take};

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
        if (start) begin
          if (divisor == 8'd0) begin
            state_d     = ST_DONE;
            quotient_d  = 8'hFF;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = ST_RUN;
            q_d     = dividend;
            r_d     = 8'd0;
            d_d     = divisor;
            cnt_d   = 3'd0;
            dbz_d   = 1'b0;
          end
        end
      end
      ST_RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = ST_DONE;
          quotient_d  = q_next;
          remainder_d = r_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      q_q         <= 8'd0;
      r_q         <= 8'd0;
      d_q         <= 8'd0;
      cnt_q       <= 3'd0;
      quotient_q  <= 8'd0;
      remainder_q <= 8'd0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      r_q         <= r_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule
